// File: rtl/tone_pkg.sv
// Shared types and constants for the tone detector: FSM states, default period
// width and the note period table (50 MHz board clock).
package tone_pkg;

    localparam int DEF_PERIOD_W = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } tone_state_t;

    // Note periods C4..D#5 in clk cycles at 50 MHz.
    localparam logic [DEF_PERIOD_W-1:0] NOTE_PERIOD [0:15] = '{
        20'd191113, 20'd180388, 20'd170265, 20'd160705,
        20'd151685, 20'd143172, 20'd135139, 20'd127551,
        20'd120395, 20'd113636, 20'd107259, 20'd101238,
        20'd95556,  20'd90194,  20'd85131,  20'd80354
    };

    localparam int NOTE_TOL = 64;

endpackage

// File: rtl/tone_sync_edge.sv
// Two-flop synchronizer for the asynchronous tone input plus a delay flop;
// rise is high for one cycle after each synchronized low-to-high transition.
module tone_sync_edge (
    input  logic clk,
    input  logic hush,
    input  logic tone_in,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (hush) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tone_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/tone_detector.sv
// Measures the rise-to-rise period of a 1-bit square wave and locks after repeated
// matching periods. Optional note decoding is enabled by TONE_DETECTOR_NOTE_DECODE_EN.
module tone_detector
    import tone_pkg::*;
#(
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int MAX_PERIOD = 2**20 - 1,
    parameter int MIN_PERIOD = 16,
    parameter int TOL        = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                clk,
    input  logic                hush,
    input  logic                tone_in,
    output logic [PERIOD_W-1:0] period,
    output logic                period_stb,
    output logic                tone_valid,
    output logic [3:0]          note,
    output logic                note_hit,
    output logic [1:0]          state_dbg
);

    localparam int MW = $clog2(STABLE_CNT + 1);
    localparam logic [PERIOD_W:0]   MIN_W    = (PERIOD_W+1)'(MIN_PERIOD);
    localparam logic [PERIOD_W:0]   TOL_W    = (PERIOD_W+1)'(TOL);
    localparam logic [PERIOD_W:0]   ONE_W    = (PERIOD_W+1)'(1);
    localparam logic [PERIOD_W-1:0] MAX_W    = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);
    localparam logic [MW-1:0]       STABLE_W = MW'(STABLE_CNT);
    localparam logic [MW-1:0]       MATCH_1  = MW'(1);

    tone_state_t         state, state_n;
    logic [PERIOD_W-1:0] cnt, cnt_n, period_n;
    logic [MW-1:0]       match_cnt, match_n;
    logic [PERIOD_W:0]   meas, diff;
    logic                rise, stb_n, mismatch;

    tone_sync_edge u_sync (
        .clk     (clk),
        .hush    (hush),
        .tone_in (tone_in),
        .rise    (rise)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        match_n  = match_cnt;
        period_n = period;
        stb_n    = 1'b0;
        meas     = {1'b0, cnt} + ONE_W;
        diff     = (meas >= {1'b0, period}) ? meas - {1'b0, period} : {1'b0, period} - meas;
        mismatch = (match_cnt == '0) || (diff > TOL_W);
        if (state == IDLE) begin
            cnt_n = '0;
            if (rise) state_n = ARMED;
        end else if (rise) begin
            cnt_n = '0;
            if (meas < MIN_W) begin
                match_n = '0;
                state_n = ARMED;
            end else begin
                period_n = meas[PERIOD_W-1:0];
                stb_n    = 1'b1;
                if (mismatch)
                    match_n = MATCH_1;
                else if (match_cnt != STABLE_W)
                    match_n = match_cnt + MATCH_1;
                state_n = (match_n == STABLE_W) ? LOCKED : ARMED;
            end
        end else if (cnt == MAX_W) begin
            // No rise for MAX_PERIOD cycles: the tone has gone away.
            state_n = IDLE;
            match_n = '0;
            cnt_n   = '0;
        end else begin
            cnt_n = cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (hush) begin
            state      <= IDLE;
            cnt        <= '0;
            match_cnt  <= '0;
            period     <= '0;
            period_stb <= 1'b0;
            tone_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            match_cnt  <= match_n;
            period     <= period_n;
            period_stb <= stb_n;
            tone_valid <= (state_n == LOCKED);
        end
    end

    assign state_dbg = state;

`ifdef TONE_DETECTOR_NOTE_DECODE_EN
    logic                scan_on, scan_done, found, entry_hit;
    logic [3:0]          idx, best;
    logic [PERIOD_W-1:0] scan_meas;
    int                  dist;

    always_comb begin
        dist = int'(scan_meas) - int'(NOTE_PERIOD[idx]);
        if (dist < 0) dist = -dist;
        entry_hit = (dist <= NOTE_TOL);
    end

    // One table entry per cycle; a new measurement restarts the scan.
    always_ff @(posedge clk) begin
        if (hush) begin
            scan_on   <= 1'b0;
            scan_done <= 1'b0;
            found     <= 1'b0;
            idx       <= '0;
            best      <= '0;
            scan_meas <= '0;
            note      <= '0;
            note_hit  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (stb_n) begin
                scan_on   <= 1'b1;
                idx       <= '0;
                found     <= 1'b0;
                scan_meas <= period_n;
            end else if (scan_on) begin
                if (entry_hit && !found) begin
                    found <= 1'b1;
                    best  <= idx;
                end
                if (idx == 4'd15) begin
                    scan_on   <= 1'b0;
                    scan_done <= 1'b1;
                end
                idx <= idx + 4'd1;
            end
            if (scan_done) begin
                note     <= best;
                note_hit <= found & (state_n == LOCKED);
            end
            if (state_n != LOCKED) note_hit <= 1'b0;
        end
    end
`else
    assign note     = 4'd0;
    assign note_hit = 1'b0;
`endif

endmodule
